sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_pick.sv | 40 ++++
 rtl/sram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state/owner encodings and counter sizing for sram_arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Bits needed to hold WAIT_CYCLES-1 (at least one bit so the counter always exists).
    function automatic int cnt_width(input int wait_cycles);
        if (wait_cycles <= 2) begin
            return 1;
        end
        return $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - grant selection; SRAM_ARB_RR_EN selects round-robin, else data-first
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant_i,
    output logic   grant_d
);

`ifdef SRAM_ARB_RR_EN
    // On a tie the port that did not win last time goes first; a lone request always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (last_owner == OWN_I) begin
                grant_d = 1'b1;
            end else begin
                grant_i = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end
`else
    // History is irrelevant for fixed priority.
    logic w_unused_last_owner;
    assign w_unused_last_owner = (last_owner == OWN_D);

    // Data port always beats instruction fetch.
    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (fetch/data) serialising arbiter for one SRAM wrapper; SRAM_ARB_RR_EN enables round-robin
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [19:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [19:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,

    output logic [19:0] io_sram_addr,
    output logic [31:0] io_sram_din,
    output logic        io_sram_en,
    output logic        io_sram_re,
    output logic        io_sram_we,
    output logic [3:0]  io_sram_wmask,
    input  logic [31:0] io_sram_dout
);

    localparam int            CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_next;
    owner_t        r_owner;
    owner_t        w_last_owner;
    logic          r_we;
    logic [CW-1:0] r_cnt;

    logic [19:0]   r_sram_addr;
    logic [31:0]   r_sram_din;
    logic          r_sram_en;
    logic          r_sram_re;
    logic          r_sram_we;
    logic [3:0]    r_sram_wmask;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_last_beat;

`ifdef SRAM_ARB_RR_EN
    // The latched owner doubles as the round-robin pointer: it resets to I and
    // is rewritten on every grant, which is exactly "last port granted".
    assign w_last_owner = r_owner;
`else
    assign w_last_owner = OWN_I;
`endif

    sram_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (w_last_owner),
        .grant_i    (w_grant_i),
        .grant_d    (w_grant_d)
    );

    assign w_last_beat = (r_cnt == '0);

    // Next state plus the combinational grant and response pulses.
    always_comb begin
        w_state_next = r_state;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                i_gnt = w_grant_i;
                d_gnt = w_grant_d;
                if (w_grant_i || w_grant_d) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_last_beat) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                i_rvalid     = (r_owner == OWN_I);
                d_done       = (r_owner == OWN_D);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register, latched command, registered SRAM controls and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_sram_addr  <= '0;
            r_sram_din   <= '0;
            r_sram_en    <= 1'b0;
            r_sram_re    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_wmask <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner      <= OWN_D;
                        r_we         <= d_we;
                        r_cnt        <= CNT_LOAD;
                        r_sram_addr  <= d_addr;
                        r_sram_din   <= d_wdata;
                        r_sram_en    <= 1'b1;
                        r_sram_re    <= ~d_we;
                        r_sram_we    <= d_we;
                        r_sram_wmask <= d_we ? d_wmask : 4'hF;
                    end else if (w_grant_i) begin
                        // Fetch is read-only: write enable forced low, full-word mask.
                        r_owner      <= OWN_I;
                        r_we         <= 1'b0;
                        r_cnt        <= CNT_LOAD;
                        r_sram_addr  <= i_addr;
                        r_sram_din   <= '0;
                        r_sram_en    <= 1'b1;
                        r_sram_re    <= 1'b1;
                        r_sram_we    <= 1'b0;
                        r_sram_wmask <= 4'hF;
                    end
                end
                ST_ACCESS: begin
                    if (w_last_beat) begin
                        // Drop strobes for RESP but keep addr/din/wmask for turnaround.
                        r_sram_en <= 1'b0;
                        r_sram_re <= 1'b0;
                        r_sram_we <= 1'b0;
                        if (!r_we) begin
                            if (r_owner == OWN_I) begin
                                r_i_rdata <= io_sram_dout;
                            end else begin
                                r_d_rdata <= io_sram_dout;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_sram_addr  = r_sram_addr;
    assign io_sram_din   = r_sram_din;
    assign io_sram_en    = r_sram_en;
    assign io_sram_re    = r_sram_re;
    assign io_sram_we    = r_sram_we;
    assign io_sram_wmask = r_sram_wmask;
    assign i_rdata       = r_i_rdata;
    assign d_rdata       = r_d_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed scoreboard bench for sram_arbiter (WAIT_CYCLES=2 and 1)
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we;
    logic [19:0] i_addr, d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        i_gnt, i_rvalid, d_gnt, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic [19:0] sram_addr;
    logic [31:0] sram_din, sram_dout;
    logic        sram_en, sram_re, sram_we;
    logic [3:0]  sram_wmask;

    logic        i_req1;
    logic [19:0] i_addr1;
    logic        i_gnt1, i_rvalid1, d_gnt1, d_done1;
    logic [31:0] i_rdata1, d_rdata1;
    logic [19:0] sram_addr1;
    logic [31:0] sram_din1, sram_dout1;
    logic        sram_en1, sram_re1, sram_we1;
    logic [3:0]  sram_wmask1;

    int total = 0;
    int bad   = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] iq1[$];
    logic [31:0] last_drd;

    // Wrapper model: fixed read pattern, driven only while a read strobe is active.
    function automatic logic [31:0] sram_word(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return {12'hA5A, a};
    endfunction

    assign sram_dout  = (sram_en && sram_re) ? sram_word(sram_addr) : 32'h0;
    assign sram_dout1 = (sram_en1 && sram_re1) ? sram_word(sram_addr1) : 32'h0;

    sram_arbiter #(.WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .io_sram_addr(sram_addr), .io_sram_din(sram_din), .io_sram_en(sram_en),
        .io_sram_re(sram_re), .io_sram_we(sram_we), .io_sram_wmask(sram_wmask),
        .io_sram_dout(sram_dout)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(20'h0), .d_wdata(32'h0), .d_wmask(4'h0),
        .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
        .io_sram_addr(sram_addr1), .io_sram_din(sram_din1), .io_sram_en(sram_en1),
        .io_sram_re(sram_re1), .io_sram_we(sram_we1), .io_sram_wmask(sram_wmask1),
        .io_sram_dout(sram_dout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_bus(input string tag, input logic en, input logic re, input logic we,
                           input logic [19:0] addr, input logic [3:0] wmask);
        chk1({tag, "_en"}, sram_en, en);
        chk1({tag, "_re"}, sram_re, re);
        chk1({tag, "_we"}, sram_we, we);
        chk({tag, "_addr"}, {12'h0, sram_addr}, {12'h0, addr});
        chk({tag, "_wmask"}, {28'h0, sram_wmask}, {28'h0, wmask});
    endtask

    // Scoreboard side: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (i_rvalid) begin
                if (iq.size() == 0) chk1("i_rvalid_unexpected", i_rvalid, 1'b0);
                else begin e = iq.pop_front(); chk("i_rdata_sb", i_rdata, e); end
            end
            if (d_done) begin
                if (dq.size() == 0) chk1("d_done_unexpected", d_done, 1'b0);
                else begin e = dq.pop_front(); chk("d_rdata_sb", d_rdata, e); end
            end
            if (i_rvalid1) begin
                if (iq1.size() == 0) chk1("i_rvalid1_unexpected", i_rvalid1, 1'b0);
                else begin e = iq1.pop_front(); chk("i_rdata1_sb", i_rdata1, e); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        i_req1 = 0; i_addr1 = '0;
        last_drd = 32'h0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        mid();
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_din", sram_din, 32'h0);
        chk_bus("rst", 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        chk1("rst_en1", sram_en1, 1'b0);
        nxt();
        reset = 1'b0;

        // instruction read of 0x00010
        i_req = 1; i_addr = 20'h00010;
        mid();
        chk1("ird_i_gnt", i_gnt, 1'b1);
        chk1("ird_d_gnt", d_gnt, 1'b0);
        chk1("ird_en_at_gnt", sram_en, 1'b0);
        iq.push_back(32'hDEADBEEF);
        nxt();
        i_req = 0;
        for (int c = 1; c <= 2; c++) begin
            mid();
            chk_bus("ird_acc", 1'b1, 1'b1, 1'b0, 20'h00010, 4'hF);
            chk1("ird_rvalid_early", i_rvalid, 1'b0);
            nxt();
        end
        mid();
        chk1("ird_rvalid", i_rvalid, 1'b1);
        chk_bus("ird_resp", 1'b0, 1'b0, 1'b0, 20'h00010, 4'hF);
        nxt();
        mid();
        chk1("ird_rvalid_once", i_rvalid, 1'b0);
        chk("ird_rdata_hold", i_rdata, 32'hDEADBEEF);
        nxt();

        // data write
        d_req = 1; d_we = 1; d_addr = 20'h00ABC; d_wdata = 32'h12345678; d_wmask = 4'h3;
        mid();
        chk1("dwr_d_gnt", d_gnt, 1'b1);
        chk1("dwr_i_gnt", i_gnt, 1'b0);
        dq.push_back(last_drd);
        nxt();
        d_req = 0;
        for (int c = 1; c <= 2; c++) begin
            mid();
            chk_bus("dwr_acc", 1'b1, 1'b0, 1'b1, 20'h00ABC, 4'h3);
            chk("dwr_din", sram_din, 32'h12345678);
            nxt();
        end
        mid();
        chk1("dwr_done", d_done, 1'b1);
        chk_bus("dwr_resp", 1'b0, 1'b0, 1'b0, 20'h00ABC, 4'h3);
        chk("dwr_din_hold", sram_din, 32'h12345678);
        nxt();
        mid();
        chk1("dwr_done_once", d_done, 1'b0);
        nxt();

        // data read of 0x00055
        d_req = 1; d_we = 0; d_addr = 20'h00055;
        mid();
        chk1("drd_d_gnt", d_gnt, 1'b1);
        last_drd = 32'hA5A00055;
        dq.push_back(last_drd);
        nxt();
        d_req = 0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            chk1("drd_done", d_done, 1'b0 ^ (c == 3));
            if (c < 3) chk_bus("drd_acc", 1'b1, 1'b1, 1'b0, 20'h00055, 4'hF);
            nxt();
        end
        mid();
        chk("drd_rdata_hold", d_rdata, 32'hA5A00055);
        nxt();

        // both requesters held for four grants
        i_req = 1; i_addr = 20'h00100;
        d_req = 1; d_we = 0; d_addr = 20'h00200;
        for (int k = 0; k < 16; k++) begin
            logic eg_i, eg_d;
`ifdef SRAM_ARB_RR_EN
            eg_d = (k % 8 == 0);
            eg_i = (k % 8 == 4);
`else
            eg_d = (k % 4 == 0);
            eg_i = 1'b0;
`endif
            mid();
            chk1("both_d_gnt", d_gnt, eg_d);
            chk1("both_i_gnt", i_gnt, eg_i);
            chk1("both_one_gnt", i_gnt & d_gnt, 1'b0);
            if (eg_d) begin last_drd = 32'hA5A00200; dq.push_back(last_drd); end
            if (eg_i) iq.push_back(32'hA5A00100);
            nxt();
        end
        i_req = 0; d_req = 0;
        mid();
        nxt();

        // data request raised during an instruction access
        i_req = 1; i_addr = 20'h00020;
        mid();
        chk1("late_i_gnt", i_gnt, 1'b1);
        iq.push_back(32'hA5A00020);
        nxt();
        i_req = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 2) begin d_req = 1; d_we = 0; d_addr = 20'h00300; end
            if (c == 5) d_req = 0;
            mid();
            chk1("late_d_gnt", d_gnt, 1'b0 ^ (c == 4));
            chk1("late_d_done", d_done, 1'b0 ^ (c == 7));
            chk1("late_i_rvalid", i_rvalid, 1'b0 ^ (c == 3));
            if (c == 4) begin last_drd = 32'hA5A00300; dq.push_back(last_drd); end
            nxt();
        end

        // reset in the middle of a data read
        d_req = 1; d_we = 0; d_addr = 20'h00400;
        mid();
        chk1("rstmid_d_gnt", d_gnt, 1'b1);
        nxt();
        d_req = 0;
        mid();
        chk1("rstmid_en_acc", sram_en, 1'b1);
        nxt();
        reset = 1'b1;
        mid();
        nxt();
        reset = 1'b0;
        last_drd = 32'h0;
        mid();
        chk_bus("rstmid_after", 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        chk1("rstmid_done", d_done, 1'b0);
        chk("rstmid_d_rdata", d_rdata, 32'h0);
        chk("rstmid_i_rdata", i_rdata, 32'h0);
        nxt();
        i_req = 1; i_addr = 20'h00010;
        mid();
        chk1("rstmid_i_gnt", i_gnt, 1'b1);
        chk1("rstmid_done4", d_done, 1'b0);
        iq.push_back(32'hDEADBEEF);
        nxt();
        i_req = 0;
        for (int c = 5; c <= 7; c++) begin
            mid();
            chk1("rstmid_i_rvalid", i_rvalid, 1'b0 ^ (c == 7));
            chk1("rstmid_no_done", d_done, 1'b0);
            nxt();
        end

        // WAIT_CYCLES=1 back-to-back fetches
        i_req1 = 1; i_addr1 = 20'h00001;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) i_addr1 = 20'h00002;
            if (c == 4) i_req1 = 0;
            mid();
            chk1("w1_i_gnt", i_gnt1, 1'b0 ^ (c == 0 || c == 3));
            chk1("w1_i_rvalid", i_rvalid1, 1'b0 ^ (c == 2 || c == 5));
            chk1("w1_en", sram_en1, 1'b0 ^ (c == 1 || c == 4));
            if (c == 1 || c == 2) chk("w1_addr_a", {12'h0, sram_addr1}, 32'h1);
            if (c == 4 || c == 5) chk("w1_addr_b", {12'h0, sram_addr1}, 32'h2);
            if (c == 0) iq1.push_back(32'hA5A00001);
            if (c == 3) iq1.push_back(32'hA5A00002);
            nxt();
        end

        repeat (2) nxt();
        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        chk("iq1_drained", 32'(iq1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
